ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter D_WIDTH, default 8, data width in bits, matched to the shared RAM.
REQ-002 Parameter A_WIDTH, default 8, address width in bits, matched to the shared RAM.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 clr  in  1  synchronous, active-high reset.
REQ-005 req0, req1  in  1 each  access request from requester 0 / 1; held high until the matching ack.
REQ-006 rw0, rw1  in  1 each  0 = read, 1 = write; stable while req is high.
REQ-007 addr0, addr1  in  A_WIDTH each  target address; stable while req is high.
REQ-008 wdata0, wdata1  in  D_WIDTH each  write data; stable while req is high.
REQ-009 ack0, ack1  out  1 each  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata  out  D_WIDTH  read data; valid only while ack0 or ack1 is high for a read.
REQ-011 busy  out  1  high in GRANT, ACCESS and RESP.
REQ-012 ram_enab  out  1  RAM chip enable.
REQ-013 ram_rw  out  1  RAM read/write select.
REQ-014 ram_addr  out  A_WIDTH  RAM address.
REQ-015 ram_wdata  out  D_WIDTH  RAM write data.
REQ-016 ram_rdata  in  D_WIDTH  RAM registered read output; one-cycle read latency; high-Z when the RAM is not enabled.

Function
REQ-017 The FSM SHALL have the states IDLE, GRANT, ACCESS and RESP.
REQ-018 IDLE: with no request, stay in IDLE; with any request, select one requester, latch its rw/addr/wdata and winner ID, and go to GRANT.
REQ-019 Arbitration is round-robin with pointer prio: both requests high selects prio; a single request is always granted; after every grant prio becomes the non-winner.
REQ-020 GRANT: drive ram_addr, ram_rw and ram_wdata from the latched values with ram_enab=0, then go to ACCESS (address setup cycle).
REQ-021 ACCESS: ram_enab=1 with the same latched values for exactly one cycle; the RAM commits the write or loads the read data at the closing edge; then go to RESP.
REQ-022 RESP: ram_enab=0; the winner's ack is high for this cycle only; rdata = ram_rdata on a read and 0 on a write; next state IDLE.
REQ-023 Outside RESP: ack0 = ack1 = 0 and rdata = 0.
REQ-024 Latency: request sampled in IDLE at edge t gives ack during cycle t+3; each transaction occupies exactly 4 cycles (IDLE through RESP).
REQ-025 Outside GRANT/ACCESS, ram_addr, ram_rw and ram_wdata SHALL be 0.
REQ-026 A request dropped before its ack is a protocol violation; a transaction already granted SHALL still complete.
REQ-027 If a requester keeps req high after its ack, it is treated as a new request in the next IDLE cycle.
REQ-028 The two acks are never high together; at most one transaction is in flight.

Reset
REQ-029 When clr is high at a clock edge, the next state is IDLE and prio = 0 (requester 0 favoured); clr overrides every other input.
REQ-030 After reset, all outputs are 0: ack0, ack1, rdata, busy, ram_enab, ram_rw, ram_addr, ram_wdata.
REQ-031 clr during GRANT or ACCESS aborts with no ack; a RAM write sampled at that same edge may still commit, and requesters must reissue.

Structure
REQ-032 The state encoding (2-bit enum, IDLE=0, GRANT=1, ACCESS=2, RESP=3) and default widths live in the shared package ram_ctrl_pkg.
REQ-033 Round-robin selection is the sub-module rr_arb2 (inputs: two requests and prio; outputs: valid and winner ID); the FSM and datapath latches stay in ram_arbiter.

Verification
REQ-034 Single write then read: req0 write addr 0x05 data 0xA5, then req0 read addr 0x05 -> ack0 at t+3 for each; rdata = 0xA5 during the read ack.
REQ-035 Contention from reset: req0 and req1 both reading, held high -> order req0, req1, req0, ...; acks 4 cycles apart, never overlapping.
REQ-036 Interleave: req1 writes 0x3C to 0x10 while req0 reads 0x10 in the same cycle from reset -> req0 is served first and sees the old value; req1 write follows; a later req0 read returns 0x3C.
REQ-037 Reset mid-ACCESS: clr pulsed during a req1 read -> no ack1; busy = 0 and ram_enab = 0 the next cycle; the held req1 restarts and acks 4 cycles after clr falls.
REQ-038 Idle check: no requests for 20 cycles -> ram_enab, busy and both acks stay 0; the prio value is unchanged.
REQ-039 Boundary: read/write at address 0xFF and data 0xFF/0x00 via requester 1 -> correct round trip and no address wrap.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the two-port RAM arbiter: FSM state encoding and
// default datapath widths.
package ram_ctrl_pkg;

    localparam int D_WIDTH_DEF = 8;
    localparam int A_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to
// the requester named by prio.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? prio : req1;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-read RAM between two requesters. Each transaction
// runs IDLE -> GRANT (address setup) -> ACCESS (enable) -> RESP (ack).
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int D_WIDTH = D_WIDTH_DEF,
    parameter int A_WIDTH = A_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               req0,
    input  logic               req1,
    input  logic               rw0,
    input  logic               rw1,
    input  logic [A_WIDTH-1:0] addr0,
    input  logic [A_WIDTH-1:0] addr1,
    input  logic [D_WIDTH-1:0] wdata0,
    input  logic [D_WIDTH-1:0] wdata1,
    output logic               ack0,
    output logic               ack1,
    output logic [D_WIDTH-1:0] rdata,
    output logic               busy,
    output logic               ram_enab,
    output logic               ram_rw,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_wdata,
    input  logic [D_WIDTH-1:0] ram_rdata
);

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic               winner_q, winner_d;
    logic               rw_q, rw_d;
    logic [A_WIDTH-1:0] addr_q, addr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;

    logic               arb_valid;
    logic               arb_winner;

    rr_arb2 u_rr_arb2 (
        .req0   (req0),
        .req1   (req1),
        .prio   (prio_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            prio_q   <= 1'b0;
            winner_q <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            winner_q <= winner_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        winner_d  = winner_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        ack0      = 1'b0;
        ack1      = 1'b0;
        rdata     = '0;
        busy      = 1'b1;
        ram_enab  = 1'b0;
        ram_rw    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (arb_valid) begin
                    winner_d = arb_winner;
                    rw_d     = arb_winner ? rw1    : rw0;
                    addr_d   = arb_winner ? addr1  : addr0;
                    wdata_d  = arb_winner ? wdata1 : wdata0;
                    prio_d   = ~arb_winner;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                ram_rw    = rw_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                state_d   = ACCESS;
            end
            ACCESS: begin
                ram_enab  = 1'b1;
                ram_rw    = rw_q;
                ram_addr  = addr_q;
                ram_wdata = wdata_q;
                state_d   = RESP;
            end
            RESP: begin
                // RAM read data arrives one cycle after the enable, i.e. now.
                ack0    = ~winner_q;
                ack1    = winner_q;
                rdata   = rw_q ? '0 : ram_rdata;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-read RAM and
// a scoreboard of expected acks (requester, timing, read data).
module tb_ram_arbiter;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          clr;
    logic          req0, req1, rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0, ack1, busy, ram_enab, ram_rw;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [AW-1:0] ram_addr;

    always #5 clk = ~clk;

    ram_arbiter #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .req0      (req0),
        .req1      (req1),
        .rw0       (rw0),
        .rw1       (rw1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .ram_enab  (ram_enab),
        .ram_rw    (ram_rw),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    // RAM model: registered read, junk pattern on the bus when not returning data.
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_q;
    logic          rd_v = 1'b0;
    always @(posedge clk) begin
        if (ram_enab) begin
            if (ram_rw) mem[ram_addr] <= ram_wdata;
            else        rd_q <= mem[ram_addr];
        end
        rd_v <= ram_enab & ~ram_rw;
    end
    assign ram_rdata = rd_v ? rd_q : 8'hEE;

    typedef struct {
        logic       id;
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         t;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] shadow [256];
    int         checks   = 0;
    int         failures = 0;
    int         cnt0     = 0;
    int         cnt1     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected result in grant order; shadow tracks what the RAM should hold.
    task automatic expect_txn(input logic id, input logic rw, input logic [7:0] a,
                              input logic [7:0] d, input int t);
        exp_t e;
        e.id    = id;
        e.rw    = rw;
        e.addr  = a;
        e.wdata = d;
        e.t     = t;
        e.rdata = rw ? 8'h00 : shadow[a];
        if (rw) shadow[a] = d;
        sb.push_back(e);
    endtask

    task automatic set_req(input logic id, input logic rw, input logic [7:0] a,
                           input logic [7:0] d, input int n);
        if (!id) begin
            rw0 = rw; addr0 = a; wdata0 = d; cnt0 = n; req0 = 1'b1;
        end else begin
            rw1 = rw; addr1 = a; wdata1 = d; cnt1 = n; req1 = 1'b1;
        end
    endtask

    task automatic serve(input int budget);
        exp_t e;
        int   t;
        t = 0;
        while (sb.size() > 0 && t < budget) begin
            tick();
            t++;
            chk("ack_overlap", {31'd0, ack0 & ack1}, 32'd0);
            if (ram_enab) begin
                chk("ram_addr",  {24'd0, ram_addr},  {24'd0, sb[0].addr});
                chk("ram_rw",    {31'd0, ram_rw},    {31'd0, sb[0].rw});
                chk("ram_wdata", {24'd0, ram_wdata}, {24'd0, sb[0].wdata});
            end
            if (!busy) begin
                chk("idle_ram_addr", {24'd0, ram_addr}, 32'd0);
            end
            if (ack0 || ack1) begin
                e = sb.pop_front();
                chk("ack_id",   {31'd0, ack1},  {31'd0, e.id});
                chk("ack_time", t,              e.t);
                chk("rdata",    {24'd0, rdata}, {24'd0, e.rdata});
                if (ack0) begin
                    cnt0--;
                    if (cnt0 <= 0) req0 = 1'b0;
                end
                if (ack1) begin
                    cnt1--;
                    if (cnt1 <= 0) req1 = 1'b0;
                end
            end
        end
        if (sb.size() > 0) begin
            chk("ack_timeout", sb.size(), 32'd0);
            sb.delete();
            req0 = 1'b0;
            req1 = 1'b0;
        end
        tick();
    endtask

    task automatic do_reset();
        req0 = 1'b0;
        req1 = 1'b0;
        clr  = 1'b1;
        tick();
        chk("rst_ack0",      {31'd0, ack0},      32'd0);
        chk("rst_ack1",      {31'd0, ack1},      32'd0);
        chk("rst_rdata",     {24'd0, rdata},     32'd0);
        chk("rst_busy",      {31'd0, busy},      32'd0);
        chk("rst_ram_enab",  {31'd0, ram_enab},  32'd0);
        chk("rst_ram_rw",    {31'd0, ram_rw},    32'd0);
        chk("rst_ram_addr",  {24'd0, ram_addr},  32'd0);
        chk("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
        clr = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rw0 = 1'b0; rw1 = 1'b0; addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
        do_reset();

        // Single write then read by requester 0, plus setup writes.
        expect_txn(1'b0, 1'b1, 8'h05, 8'hA5, 3); set_req(1'b0, 1'b1, 8'h05, 8'hA5, 1); serve(12);
        expect_txn(1'b0, 1'b0, 8'h05, 8'h00, 3); set_req(1'b0, 1'b0, 8'h05, 8'h00, 1); serve(12);
        expect_txn(1'b0, 1'b1, 8'h10, 8'h5A, 3); set_req(1'b0, 1'b1, 8'h10, 8'h5A, 1); serve(12);
        expect_txn(1'b0, 1'b1, 8'h00, 8'h11, 3); set_req(1'b0, 1'b1, 8'h00, 8'h11, 1); serve(12);

        // Idle: nothing moves, and prio (now favouring requester 1) is kept.
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_ram_enab", {31'd0, ram_enab}, 32'd0);
            chk("idle_busy",     {31'd0, busy},     32'd0);
            chk("idle_ack0",     {31'd0, ack0},     32'd0);
            chk("idle_ack1",     {31'd0, ack1},     32'd0);
        end
        expect_txn(1'b1, 1'b0, 8'h10, 8'h00, 3);
        expect_txn(1'b0, 1'b0, 8'h00, 8'h00, 7);
        set_req(1'b0, 1'b0, 8'h00, 8'h00, 1);
        set_req(1'b1, 1'b0, 8'h10, 8'h00, 1);
        serve(20);

        // Contention from reset: 0,1,0,1 four cycles apart.
        do_reset();
        expect_txn(1'b0, 1'b0, 8'h05, 8'h00, 3);
        expect_txn(1'b1, 1'b0, 8'h00, 8'h00, 7);
        expect_txn(1'b0, 1'b0, 8'h05, 8'h00, 11);
        expect_txn(1'b1, 1'b0, 8'h00, 8'h00, 15);
        set_req(1'b0, 1'b0, 8'h05, 8'h00, 2);
        set_req(1'b1, 1'b0, 8'h00, 8'h00, 2);
        serve(30);

        // Interleave: req0 reads the old value, then req1's write lands.
        do_reset();
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 3);
        expect_txn(1'b1, 1'b1, 8'h10, 8'h3C, 7);
        set_req(1'b0, 1'b0, 8'h10, 8'h00, 1);
        set_req(1'b1, 1'b1, 8'h10, 8'h3C, 1);
        serve(20);
        expect_txn(1'b0, 1'b0, 8'h10, 8'h00, 3); set_req(1'b0, 1'b0, 8'h10, 8'h00, 1); serve(12);

        // Reset mid-ACCESS: aborted read, then the held request restarts.
        set_req(1'b1, 1'b0, 8'h10, 8'h00, 1);
        tick();
        chk("mid_grant_busy", {31'd0, busy},     32'd1);
        chk("mid_grant_enab", {31'd0, ram_enab}, 32'd0);
        tick();
        chk("mid_access_enab", {31'd0, ram_enab}, 32'd1);
        clr = 1'b1;
        tick();
        chk("mid_clr_ack1", {31'd0, ack1},     32'd0);
        chk("mid_clr_busy", {31'd0, busy},     32'd0);
        chk("mid_clr_enab", {31'd0, ram_enab}, 32'd0);
        clr = 1'b0;
        expect_txn(1'b1, 1'b0, 8'h10, 8'h00, 3);
        serve(12);

        // Boundary address/data through requester 1, and address 0 untouched.
        expect_txn(1'b1, 1'b1, 8'hFF, 8'hFF, 3); set_req(1'b1, 1'b1, 8'hFF, 8'hFF, 1); serve(12);
        expect_txn(1'b1, 1'b0, 8'hFF, 8'h00, 3); set_req(1'b1, 1'b0, 8'hFF, 8'h00, 1); serve(12);
        expect_txn(1'b1, 1'b1, 8'hFF, 8'h00, 3); set_req(1'b1, 1'b1, 8'hFF, 8'h00, 1); serve(12);
        expect_txn(1'b1, 1'b0, 8'hFF, 8'h00, 3); set_req(1'b1, 1'b0, 8'hFF, 8'h00, 1); serve(12);
        expect_txn(1'b1, 1'b0, 8'h00, 8'h00, 3); set_req(1'b1, 1'b0, 8'h00, 8'h00, 1); serve(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
